// File: rtl/link_vc_scheduler_if.sv
// Link-side bundle between the output-port VC buffers and the link scheduler.
// The master is the buffer/downstream side, and the slave is the scheduler.
interface link_vc_scheduler_if #(
  parameter int VC_NUM = 4,
  parameter int DATA_W = 32
);
  logic [VC_NUM-1:0]             vc_valid;
  logic [VC_NUM-1:0][DATA_W-1:0] vc_data;
  logic [VC_NUM-1:0]             vc_head;
  logic [VC_NUM-1:0]             vc_tail;
  logic [VC_NUM-1:0]             vc_grant;
  logic [VC_NUM-1:0]             is_on_off;
  logic [DATA_W-1:0]             data;
  logic                          is_valid;
  logic [VC_NUM-1:0]             pkt_active;

  modport master (
    output vc_valid, vc_data, vc_head, vc_tail, is_on_off,
    input  vc_grant, data, is_valid, pkt_active
  );

  modport slave (
    input  vc_valid, vc_data, vc_head, vc_tail, is_on_off,
    output vc_grant, data, is_valid, pkt_active
  );
endinterface

// File: rtl/link_vc_scheduler.sv
// Shares one link between VC_NUM virtual channels using round-robin arbitration and on/off flow control.
// Optionally holds the grant on a VC from its HEAD flit to its TAIL flit, and registers the chosen flit onto the link.
module link_vc_scheduler #(
  parameter int VC_NUM      = 4,
  parameter int DATA_W      = 32,
  parameter bit LOCK_PACKET = 1'b0
) (
  input logic               clk,
  input logic               rst,
  link_vc_scheduler_if.slave bus
);
  localparam int PTR_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  lock_vc;
  logic [VC_NUM-1:0] pkt_active;
  logic [VC_NUM-1:0] eligible;
  logic [VC_NUM-1:0] grant_p0;
  logic [PTR_W-1:0]  gnt_idx_p0;
  logic              vld_p0;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              proto_err;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= VC_NUM) sum = sum - VC_NUM;
    return PTR_W'(sum);
  endfunction

  // Stage p0: combinational grant selection
  always_comb begin
    eligible   = bus.vc_valid & bus.is_on_off;
    grant_p0   = '0;
    gnt_idx_p0 = '0;
    vld_p0     = 1'b0;
    if (!rst) begin
      if (state == LOCKED) begin
        if (eligible[lock_vc]) begin
          vld_p0     = 1'b1;
          gnt_idx_p0 = lock_vc;
        end
      end else begin
        // Walk backwards so the last hit is the first eligible VC at or after rr_ptr.
        for (int i = VC_NUM - 1; i >= 0; i--) begin
          if (eligible[wrap_add(rr_ptr, i)]) begin
            vld_p0     = 1'b1;
            gnt_idx_p0 = wrap_add(rr_ptr, i);
          end
        end
      end
    end
    if (vld_p0) grant_p0[gnt_idx_p0] = 1'b1;
  end

  // Stage p1: registered link output and scheduler state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock_vc    <= '0;
      pkt_active <= '0;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        data_p1 <= bus.vc_data[gnt_idx_p0];
        rr_ptr  <= wrap_add(gnt_idx_p0, 1);
        if (bus.vc_head[gnt_idx_p0] && !bus.vc_tail[gnt_idx_p0])
          pkt_active[gnt_idx_p0] <= 1'b1;
        else if (bus.vc_tail[gnt_idx_p0])
          pkt_active[gnt_idx_p0] <= 1'b0;
        case (state)
          IDLE: begin
            if (LOCK_PACKET && bus.vc_head[gnt_idx_p0] && !bus.vc_tail[gnt_idx_p0]) begin
              state   <= LOCKED;
              lock_vc <= gnt_idx_p0;
            end
          end
          LOCKED: begin
            if (bus.vc_tail[gnt_idx_p0]) state <= IDLE;
          end
        endcase
      end
    end
  end

  // A HEAD flit must open a packet, and any other flit must continue one.
  always_comb proto_err = vld_p0 && (bus.vc_head[gnt_idx_p0] == pkt_active[gnt_idx_p0]);

  assert property (@(posedge clk) disable iff (rst) !proto_err);

  assign bus.vc_grant   = grant_p0;
  assign bus.data       = data_p1;
  assign bus.is_valid   = vld_p1;
  assign bus.pkt_active = pkt_active;
endmodule

// File: tb/tb_link_vc_scheduler.sv
// Bench for link_vc_scheduler: one per-flit round-robin instance and one packet-locking instance.
// Both are driven from per-VC flit queues and checked against a reference model and scoreboard.
module tb_link_vc_scheduler;
  localparam int VC_NUM = 4;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              head;
    logic              tail;
  } flit_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [VC_NUM-1:0] pact;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  link_vc_scheduler_if #(.VC_NUM(VC_NUM), .DATA_W(DATA_W)) bus0 ();
  link_vc_scheduler_if #(.VC_NUM(VC_NUM), .DATA_W(DATA_W)) bus1 ();

  link_vc_scheduler #(.VC_NUM(VC_NUM), .DATA_W(DATA_W), .LOCK_PACKET(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  link_vc_scheduler #(.VC_NUM(VC_NUM), .DATA_W(DATA_W), .LOCK_PACKET(1'b1)) dut_lock (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int    checks   = 0;
  int    failures = 0;
  bit    sel      = 1'b0;
  flit_t srcq [VC_NUM][$];
  exp_t  sb[$];
  int    glog[$];
  int    exp_seq[$];

  int                m_rr      = 0;
  bit                m_locked  = 1'b0;
  int                m_lock_vc = 0;
  logic [VC_NUM-1:0] m_pact    = '0;
  logic [DATA_W-1:0] m_data    = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_flit(input int v, input int seq, input logic h, input logic t);
    flit_t f;
    f.data = DATA_W'(v * 256 + seq);
    f.head = h;
    f.tail = t;
    srcq[v].push_back(f);
  endtask

  task automatic step(input logic [VC_NUM-1:0] on, input logic r);
    logic [VC_NUM-1:0]             valid, head, tail, dg, eg;
    logic [VC_NUM-1:0][DATA_W-1:0] fdata;
    int   mgi, gi;
    exp_t e;
    valid = '0; head = '0; tail = '0; fdata = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (srcq[v].size() > 0) begin
        valid[v] = 1'b1;
        fdata[v] = srcq[v][0].data;
        head[v]  = srcq[v][0].head;
        tail[v]  = srcq[v][0].tail;
      end
    end
    rst            = r;
    bus0.vc_valid  = sel ? '0 : valid;
    bus1.vc_valid  = sel ? valid : '0;
    bus0.vc_data   = fdata;  bus1.vc_data  = fdata;
    bus0.vc_head   = head;   bus1.vc_head  = head;
    bus0.vc_tail   = tail;   bus1.vc_tail  = tail;
    bus0.is_on_off = on;     bus1.is_on_off = on;

    mgi = -1;
    if (!r) begin
      if (sel && m_locked) begin
        if (valid[m_lock_vc] && on[m_lock_vc]) mgi = m_lock_vc;
      end else begin
        for (int i = 0; i < VC_NUM; i++) begin
          int idx;
          idx = (m_rr + i) % VC_NUM;
          if (mgi < 0 && valid[idx] && on[idx]) mgi = idx;
        end
      end
    end
    eg = '0;
    if (mgi >= 0) eg[mgi] = 1'b1;

    #1;
    dg = sel ? bus1.vc_grant : bus0.vc_grant;
    chk("grant", 32'(dg), 32'(eg));
    gi = -1;
    for (int v = 0; v < VC_NUM; v++) if (dg[v]) gi = v;
    glog.push_back(gi);

    if (r) begin
      m_rr = 0; m_locked = 1'b0; m_lock_vc = 0; m_pact = '0; m_data = '0;
    end else if (mgi >= 0) begin
      m_data = fdata[mgi];
      if (head[mgi] && !tail[mgi]) m_pact[mgi] = 1'b1;
      else if (tail[mgi]) m_pact[mgi] = 1'b0;
      if (sel && !m_locked && head[mgi] && !tail[mgi]) begin
        m_locked  = 1'b1;
        m_lock_vc = mgi;
      end else if (sel && m_locked && tail[mgi]) begin
        m_locked = 1'b0;
      end
      m_rr = (mgi + 1) % VC_NUM;
    end
    e.vld  = !r && (mgi >= 0);
    e.data = m_data;
    e.pact = m_pact;
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("is_valid",   32'(sel ? bus1.is_valid   : bus0.is_valid),   32'(e.vld));
    chk("data",       32'(sel ? bus1.data       : bus0.data),       32'(e.data));
    chk("pkt_active", 32'(sel ? bus1.pkt_active : bus0.pkt_active), 32'(e.pact));
    if (mgi >= 0) void'(srcq[mgi].pop_front());
  endtask

  task automatic start_test(input bit s);
    sel = s;
    for (int v = 0; v < VC_NUM; v++) srcq[v].delete();
    step('1, 1'b1);
    glog.delete();
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, 32'(glog.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < glog.size(); i++)
      chk(tag, 32'(glog[i]), 32'(exp_seq[i]));
  endtask

  initial begin
    bus0.vc_valid = '0; bus0.vc_data = '0; bus0.vc_head = '0; bus0.vc_tail = '0; bus0.is_on_off = '0;
    bus1.vc_valid = '0; bus1.vc_data = '0; bus1.vc_head = '0; bus1.vc_tail = '0; bus1.is_on_off = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_vld0",  32'(bus0.is_valid),   32'd0);
    chk("rst_data0", 32'(bus0.data),       32'd0);
    chk("rst_pact0", 32'(bus0.pkt_active), 32'd0);
    chk("rst_vld1",  32'(bus1.is_valid),   32'd0);
    chk("rst_data1", 32'(bus1.data),       32'd0);
    chk("rst_pact1", 32'(bus1.pkt_active), 32'd0);

    // All VCs busy with single-flit packets: strict rotation.
    start_test(1'b0);
    for (int v = 0; v < VC_NUM; v++)
      for (int s = 0; s < 3; s++) push_flit(v, s, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) step('1, 1'b0);
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_seq("t1_seq");

    // Lone VC held off downstream for three cycles, then the pointer moves past it.
    start_test(1'b0);
    push_flit(2, 0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) step(4'b1011, 1'b0);
    step('1, 1'b0);
    push_flit(0, 1, 1'b1, 1'b1);
    push_flit(1, 1, 1'b1, 1'b1);
    push_flit(3, 1, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) step('1, 1'b0);
    exp_seq = '{-1, -1, -1, 2, 3, 0, 1};
    check_seq("t2_seq");

    // Locked packet on VC1 while VC0 and VC3 wait.
    start_test(1'b1);
    push_flit(1, 0, 1'b1, 1'b0);
    push_flit(1, 1, 1'b0, 1'b0);
    push_flit(1, 2, 1'b0, 1'b1);
    step('1, 1'b0);
    push_flit(0, 0, 1'b1, 1'b1);
    push_flit(3, 0, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) step('1, 1'b0);
    exp_seq = '{1, 1, 1, 3, 0};
    check_seq("t3_seq");

    // Locked VC1 stalled by flow control: bubbles, nobody else may jump in.
    start_test(1'b1);
    push_flit(1, 0, 1'b1, 1'b0);
    push_flit(1, 1, 1'b0, 1'b0);
    push_flit(1, 2, 1'b0, 1'b1);
    step('1, 1'b0);
    push_flit(0, 0, 1'b1, 1'b1);
    push_flit(3, 0, 1'b1, 1'b1);
    step(4'b1101, 1'b0);
    step(4'b1101, 1'b0);
    for (int c = 0; c < 4; c++) step('1, 1'b0);
    exp_seq = '{1, -1, -1, 1, 1, 3, 0};
    check_seq("t4_seq");

    // Per-flit round robin interleaves two multi-flit packets.
    start_test(1'b0);
    for (int v = 0; v < 2; v++) begin
      push_flit(v, 0, 1'b1, 1'b0);
      push_flit(v, 1, 1'b0, 1'b0);
      push_flit(v, 2, 1'b0, 1'b1);
    end
    for (int c = 0; c < 7; c++) step('1, 1'b0);
    exp_seq = '{0, 1, 0, 1, 0, 1, -1};
    check_seq("t5_seq");

    // Reset in the middle of a locked packet returns to IDLE with pointer 0.
    start_test(1'b1);
    for (int v = 1; v < 3; v++) begin
      push_flit(v, 0, 1'b1, 1'b0);
      push_flit(v, 1, 1'b0, 1'b0);
      push_flit(v, 2, 1'b0, 1'b1);
    end
    step('1, 1'b0);
    step('1, 1'b1);
    for (int v = 0; v < VC_NUM; v++) srcq[v].delete();
    push_flit(1, 5, 1'b1, 1'b1);
    push_flit(3, 5, 1'b1, 1'b1);
    step('1, 1'b0);
    step('1, 1'b0);
    exp_seq = '{1, -1, 1, 3};
    check_seq("t6_seq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
